// File: rtl/jump_pkg.sv
// Shared types and constants for the jump/fall/land controller and its velocity datapath.
package jump_pkg;

  localparam int unsigned CNT_W = 11;
  localparam logic [CNT_W-1:0] PURE_GRAV_LOAD = 11'd340;

  typedef enum logic [2:0] {
    INIT,
    GROUND,
    AIR_WAIT,
    AIR_SETTLE,
    AIR_APPLY,
    LAND
  } state_t;

  typedef logic signed [7:0] vel_t;

endpackage

// File: rtl/jump_vel_calc.sv
// Combinational velocity/position step: converts the gravity Count into a clamped
// vertical velocity and the next player Y, with ceiling/floor/landing decisions.
module jump_vel_calc
  import jump_pkg::*;
#(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 440,
  parameter int V0         = 10,
  parameter int GRAV_SHIFT = 5,
  parameter int MAX_FALL   = 8
) (
  input  logic [CNT_W-1:0] grav_count,
  input  logic [9:0]       player_y,
  input  logic             on_ground,
  output vel_t             vy,
  output logic [9:0]       y_out,
  output logic             land,
  output logic             hold
);

  localparam logic signed [11:0] V0_S    = 12'(V0);
  localparam logic signed [11:0] FALL_S  = 12'(-MAX_FALL);
  localparam logic signed [11:0] YMIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);
  localparam logic [9:0]         YMIN_U  = 10'(Y_MIN);
  localparam logic [9:0]         YMAX_U  = 10'(Y_MAX);
  localparam logic [CNT_W-1:0]   CNT_HOLD = CNT_W'((V0 + MAX_FALL) << GRAV_SHIFT);

  logic [CNT_W-1:0]   shifted;
  logic signed [11:0] vy_raw;
  logic signed [11:0] vy_c;
  logic signed [11:0] y_next;
  logic               ceil_hit;
  logic               floor_hit;

  always_comb begin
    shifted   = grav_count >> GRAV_SHIFT;
    vy_raw    = V0_S - $signed({1'b0, shifted});
    vy_c      = (vy_raw < FALL_S) ? FALL_S : vy_raw;
    y_next    = $signed({2'b00, player_y}) - vy_c;
    ceil_hit  = (y_next < YMIN_S);
    floor_hit = (y_next >= YMAX_S);
    // Ceiling clamp takes priority and keeps the player airborne.
    land      = !ceil_hit && (floor_hit || (on_ground && (vy_c <= 12'sd0)));
    vy        = vel_t'(vy_c);
    if (ceil_hit) begin
      y_out = YMIN_U;
    end else if (floor_hit) begin
      y_out = YMAX_U;
    end else begin
      y_out = 10'(y_next);
    end
    hold = (grav_count >= CNT_HOLD);
  end

endmodule

// File: rtl/jump_physics_ctrl.sv
// Jump/fall/land FSM: sole driver of the gravity counter controls, integrates the
// per-frame velocity derived from its Count into player Y.
module jump_physics_ctrl
  import jump_pkg::*;
#(
  parameter int Y_INIT     = 400,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 440,
  parameter int V0         = 10,
  parameter int GRAV_SHIFT = 5,
  parameter int MAX_FALL   = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             frame_tick,
  input  logic             jump_btn,
  input  logic             on_ground,
  input  logic [CNT_W-1:0] grav_count,
  output logic             cnt_enable,
  output logic             cnt_pure_grav,
  output logic             cnt_reset,
  output logic [9:0]       player_y,
  output vel_t             vel_y,
  output logic             airborne
);

  state_t     state, state_nx;
  logic       en_nx, pg_nx, rst_nx, air_nx;
  logic [9:0] y_nx;
  vel_t       vel_nx;

  vel_t       vy_calc;
  logic [9:0] y_calc;
  logic       land_calc;
  logic       hold_calc;

  jump_vel_calc #(
    .Y_MIN      (Y_MIN),
    .Y_MAX      (Y_MAX),
    .V0         (V0),
    .GRAV_SHIFT (GRAV_SHIFT),
    .MAX_FALL   (MAX_FALL)
  ) u_vel_calc (
    .grav_count (grav_count),
    .player_y   (player_y),
    .on_ground  (on_ground),
    .vy         (vy_calc),
    .y_out      (y_calc),
    .land       (land_calc),
    .hold       (hold_calc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= INIT;
      player_y      <= 10'(Y_INIT);
      vel_y         <= '0;
      cnt_enable    <= 1'b0;
      cnt_pure_grav <= 1'b0;
      cnt_reset     <= 1'b0;
      airborne      <= 1'b0;
    end else begin
      state         <= state_nx;
      player_y      <= y_nx;
      vel_y         <= vel_nx;
      cnt_enable    <= en_nx;
      cnt_pure_grav <= pg_nx;
      cnt_reset     <= rst_nx;
      airborne      <= air_nx;
    end
  end

  // Counter pulses are decoded from the next state so each is registered and
  // at most one kind of command is issued per cycle.
  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    pg_nx    = 1'b0;
    rst_nx   = 1'b0;
    y_nx     = player_y;
    vel_nx   = vel_y;
    unique case (state)
      INIT: begin
        rst_nx   = 1'b1;
        state_nx = GROUND;
      end
      GROUND: begin
        vel_nx = '0;
        if (frame_tick) begin
          if (!on_ground) begin
            en_nx    = 1'b1;
            pg_nx    = 1'b1;
            state_nx = AIR_SETTLE;
          end else if (jump_btn) begin
            rst_nx   = 1'b1;
            state_nx = AIR_WAIT;
          end
        end
      end
      AIR_WAIT: begin
        if (frame_tick) begin
          en_nx    = !hold_calc;
          state_nx = AIR_SETTLE;
        end
      end
      AIR_SETTLE: begin
        state_nx = AIR_APPLY;
      end
      AIR_APPLY: begin
        vel_nx   = vy_calc;
        y_nx     = y_calc;
        state_nx = land_calc ? LAND : AIR_WAIT;
      end
      LAND: begin
        rst_nx   = 1'b1;
        vel_nx   = '0;
        state_nx = GROUND;
      end
      default: begin
        state_nx = INIT;
      end
    endcase
    air_nx = (state_nx == AIR_WAIT) || (state_nx == AIR_SETTLE) || (state_nx == AIR_APPLY);
  end

endmodule
